// File: rtl/bumpy_pkg.sv
// rtl/bumpy_pkg.sv - shared constants and FSM state type for the bumpy collision block
// Contents: object request bit indices, bumpy edge-code bit positions, FSM state enum.
package bumpy_pkg;

    // Bit positions inside objDrawingRequest
    localparam int OBJ_PLATFORM = 0;
    localparam int OBJ_WALL     = 1;
    localparam int OBJ_HAZARD   = 2;
    localparam int OBJ_GOAL     = 3;
    localparam int N_OBJ        = 4;

    // Bit positions inside bumpyHitEdgeCode ({Left,Top,Right,Bottom})
    localparam int LEFT   = 3;
    localparam int TOP    = 2;
    localparam int RIGHT  = 1;
    localparam int BOTTOM = 0;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

endpackage

// File: rtl/bumpy_collision_if.sv
// rtl/bumpy_collision_if.sv - pixel-request inputs and frame-summary outputs of bumpy_collision
// Ports (signals):
//   startOfFrame, bumpyDrawingRequest, bumpyHitEdgeCode[3:0], objDrawingRequest[3:0] : to collision block
//   collisionValid, solidEdge[3:0], hazardHit, goalHit, overlapCount[CNT_WIDTH-1:0]  : from collision block
// Modports: master drives pixel requests and observes reports; slave is the collision block.
interface bumpy_collision_if #(
    parameter int CNT_WIDTH = 8
);

    logic                 startOfFrame;
    logic                 bumpyDrawingRequest;
    logic [3:0]           bumpyHitEdgeCode;
    logic [3:0]           objDrawingRequest;

    logic                 collisionValid;
    logic [3:0]           solidEdge;
    logic                 hazardHit;
    logic                 goalHit;
    logic [CNT_WIDTH-1:0] overlapCount;

    modport master (
        output startOfFrame,
        output bumpyDrawingRequest,
        output bumpyHitEdgeCode,
        output objDrawingRequest,
        input  collisionValid,
        input  solidEdge,
        input  hazardHit,
        input  goalHit,
        input  overlapCount
    );

    modport slave (
        input  startOfFrame,
        input  bumpyDrawingRequest,
        input  bumpyHitEdgeCode,
        input  objDrawingRequest,
        output collisionValid,
        output solidEdge,
        output hazardHit,
        output goalHit,
        output overlapCount
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear and load
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   clear               : synchronous clear to 0 (priority over load)
//   load, load_value    : synchronous load (priority over increment)
//   inc                 : increment by one, sticking at all-ones
//   count[WIDTH-1:0]    : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VALUE = '1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && (count != MAX_VALUE)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bumpy_collision.sv
// rtl/bumpy_collision.sv - per-frame collision summary between bumpy and scene objects
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : bumpy_collision_if.slave - pixel requests in, frame summary out
// Accumulates overlap information over a frame and publishes it on each
// startOfFrame, with collisionValid pulsing the cycle after.
module bumpy_collision
    import bumpy_pkg::*;
#(
    parameter int unsigned MIN_HAZARD_PIXELS = 4,
    parameter int          CNT_WIDTH         = 8
) (
    input  logic            clk,
    input  logic            reset,
    bumpy_collision_if.slave bus
);

    state_t state, state_nxt;

    logic                 acc_clear;
    logic                 accumulate;
    logic                 frame_end;

    logic [N_OBJ-1:0]     overlap;
    logic                 solid_px;
    logic                 hazard_px;
    logic                 goal_px;
    logic                 any_px;

    logic [3:0]           edge_acc;
    logic                 goal_acc;
    logic [CNT_WIDTH-1:0] hazard_cnt;
    logic [CNT_WIDTH-1:0] total_cnt;

    logic                 valid_r;
    logic [3:0]           solid_edge_r;
    logic                 hazard_hit_r;
    logic                 goal_hit_r;
    logic [CNT_WIDTH-1:0] overlap_count_r;

    assign overlap   = {N_OBJ{bus.bumpyDrawingRequest}} & bus.objDrawingRequest;
    assign solid_px  = overlap[OBJ_PLATFORM] | overlap[OBJ_WALL];
    assign hazard_px = overlap[OBJ_HAZARD];
    assign goal_px   = overlap[OBJ_GOAL];
    // A pixel touching several objects still counts once in the total.
    assign any_px    = |overlap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_clear  = 1'b0;
        accumulate = 1'b0;
        frame_end  = 1'b0;
        case (state)
            WAIT_SYNC: begin
                // Not frame-aligned yet: discard pixels and wait for a frame boundary.
                acc_clear = 1'b1;
                if (bus.startOfFrame) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.startOfFrame) begin
                    frame_end = 1'b1;
                end else begin
                    accumulate = 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_SYNC;
            end
        endcase
    end

    // On a frame boundary the counters reload with the boundary cycle's own
    // pixel, which belongs to the new frame.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_hazard_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .load       (frame_end),
        .load_value (CNT_WIDTH'(hazard_px)),
        .inc        (accumulate & hazard_px),
        .count      (hazard_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_total_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .load       (frame_end),
        .load_value (CNT_WIDTH'(any_px)),
        .inc        (accumulate & any_px),
        .count      (total_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_acc        <= 4'h0;
            goal_acc        <= 1'b0;
            valid_r         <= 1'b0;
            solid_edge_r    <= 4'h0;
            hazard_hit_r    <= 1'b0;
            goal_hit_r      <= 1'b0;
            overlap_count_r <= '0;
        end else begin
            valid_r <= frame_end;
            if (acc_clear) begin
                edge_acc <= 4'h0;
                goal_acc <= 1'b0;
            end else if (frame_end) begin
                // Publish the finished frame (accumulators exclude this cycle).
                solid_edge_r    <= edge_acc;
                hazard_hit_r    <= (32'(hazard_cnt) >= MIN_HAZARD_PIXELS);
                goal_hit_r      <= goal_acc;
                overlap_count_r <= total_cnt;
                edge_acc        <= solid_px ? bus.bumpyHitEdgeCode : 4'h0;
                goal_acc        <= goal_px;
            end else if (accumulate) begin
                if (solid_px) begin
                    edge_acc <= edge_acc | bus.bumpyHitEdgeCode;
                end
                if (goal_px) begin
                    goal_acc <= 1'b1;
                end
            end
        end
    end

    assign bus.collisionValid = valid_r;
    assign bus.solidEdge      = solid_edge_r;
    assign bus.hazardHit      = hazard_hit_r;
    assign bus.goalHit        = goal_hit_r;
    assign bus.overlapCount   = overlap_count_r;

endmodule

// File: tb/tb_bumpy_collision.sv
// tb/tb_bumpy_collision.sv - scoreboard bench for bumpy_collision (MIN_HAZARD_PIXELS 4 and 0)
module tb_bumpy_collision;
    import bumpy_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bumpy_collision_if #(.CNT_WIDTH(8)) if0 ();
    bumpy_collision_if #(.CNT_WIDTH(8)) if1 ();

    bumpy_collision #(.MIN_HAZARD_PIXELS(4), .CNT_WIDTH(8)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    bumpy_collision #(.MIN_HAZARD_PIXELS(0), .CNT_WIDTH(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    // haz0 is the hazardHit expected from the MIN_HAZARD_PIXELS=0 instance.
    typedef struct packed {
        logic [3:0] solid;
        logic       haz;
        logic       haz0;
        logic       goal;
        logic [7:0] cnt;
    } rep_t;

    rep_t exp_q[$];
    rep_t last;
    bit   running;
    int   tests;
    int   fails;

    function automatic rep_t rep(input logic [3:0] s, input logic h, input logic g, input logic [7:0] c);
        rep_t r;
        r.solid = s;
        r.haz   = h;
        r.haz0  = 1'b1;
        r.goal  = g;
        r.cnt   = c;
        return r;
    endfunction

    // One clock of stimulus; checks pulse timing and held/published values.
    task automatic step(input logic r, input logic sof, input logic b, input logic [3:0] e, input logic [3:0] o);
        bit   exp_v;
        rep_t got0;
        logic [12:0] got1;
        reset = r;
        if0.startOfFrame = sof; if0.bumpyDrawingRequest = b;
        if0.bumpyHitEdgeCode = e; if0.objDrawingRequest = o;
        if1.startOfFrame = sof; if1.bumpyDrawingRequest = b;
        if1.bumpyHitEdgeCode = e; if1.objDrawingRequest = o;
        exp_v = !r && sof && running;
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard_empty: report due at t=%0t but nothing queued", $time);
            end else begin
                last = exp_q.pop_front();
            end
        end
        if (r) begin
            running = 1'b0;
            last    = '0;
        end else if (sof) begin
            running = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (if0.collisionValid !== exp_v) begin
            fails++;
            $display("FAIL valid0 t=%0t: got %b expected %b", $time, if0.collisionValid, exp_v);
        end
        tests++;
        if (if1.collisionValid !== exp_v) begin
            fails++;
            $display("FAIL valid1 t=%0t: got %b expected %b", $time, if1.collisionValid, exp_v);
        end
        got0 = {if0.solidEdge, if0.hazardHit, if1.hazardHit, if0.goalHit, if0.overlapCount};
        tests++;
        if (got0 !== last) begin
            fails++;
            $display("FAIL report t=%0t: got edge=%h haz=%b haz0=%b goal=%b cnt=%0d expected edge=%h haz=%b haz0=%b goal=%b cnt=%0d",
                     $time, got0.solid, got0.haz, got0.haz0, got0.goal, got0.cnt,
                     last.solid, last.haz, last.haz0, last.goal, last.cnt);
        end
        got1 = {if1.solidEdge, if1.goalHit, if1.overlapCount};
        tests++;
        if (got1 !== {last.solid, last.goal, last.cnt}) begin
            fails++;
            $display("FAIL report1 t=%0t: got %h expected %h", $time, got1, {last.solid, last.goal, last.cnt});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic px(input int n, input logic [3:0] e, input logic [3:0] o);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, e, o);
    endtask

    task automatic sof();
        step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        tests++;
        if ({if0.collisionValid, if0.solidEdge, if0.hazardHit, if0.goalHit, if0.overlapCount} !== 15'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {if0.collisionValid, if0.solidEdge, if0.hazardHit, if0.goalHit, if0.overlapCount});
        end
    endtask

    task automatic test_no_overlap();
        idle(3);
        px(2, 4'hF, 4'hF);              // ignored before first frame sync
        sof();                          // sync only, no report
        idle(4);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b0, 8'd0));
        sof();
        idle(5);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b0, 8'd0));
        sof();
    endtask

    task automatic test_solid();
        px(10, 4'h1, 4'b0001);          // platform, bottom edge
        px(2, 4'h8, 4'b0010);           // wall, left edge
        px(3, 4'h4, 4'b0000);           // bumpy alone: no overlap
        step(1'b0, 1'b0, 1'b0, 4'h2, 4'b0011); // objects without bumpy
        exp_q.push_back(rep(4'h9, 1'b0, 1'b0, 8'd12));
        sof();
    endtask

    task automatic test_hazard();
        px(3, 4'h2, 4'b0100);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b0, 8'd3));
        sof();
        px(4, 4'h2, 4'b0100);
        exp_q.push_back(rep(4'h0, 1'b1, 1'b0, 8'd4));
        sof();
    endtask

    task automatic test_saturation();
        px(300, 4'h0, 4'b0001);
        px(1, 4'h0, 4'hF);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b1, 8'd255));
        sof();
        px(1, 4'h0, 4'hF);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b1, 8'd1));
        sof();
    endtask

    task automatic test_sof_pixel();
        idle(2);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b0, 8'd0));
        step(1'b0, 1'b1, 1'b1, 4'h2, 4'b0001);
        idle(2);
        exp_q.push_back(rep(4'h2, 1'b0, 1'b0, 8'd1));
        sof();
    endtask

    task automatic test_back_to_back();
        idle(1);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b0, 8'd0));
        step(1'b0, 1'b1, 1'b1, 4'h4, 4'b0010);
        exp_q.push_back(rep(4'h4, 1'b0, 1'b0, 8'd1));
        sof();
        idle(1);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b0, 8'd0));
        sof();
    endtask

    task automatic test_reset_mid();
        px(5, 4'h8, 4'b0101);
        step(1'b1, 1'b0, 1'b1, 4'h8, 4'b0101);
        idle(2);
        sof();                          // resync only, no report
        px(2, 4'h0, 4'b1000);
        exp_q.push_back(rep(4'h0, 1'b0, 1'b1, 8'd2));
        sof();
        idle(2);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        running = 1'b0;
        last    = '0;
        test_reset();
        test_no_overlap();
        test_solid();
        test_hazard();
        test_saturation();
        test_sof_pixel();
        test_back_to_back();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_reports: %0d still queued, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
